// File: rtl/difftest_pkt_arbiter.sv
// difftest_pkt_arbiter
// Round-robin scheduler that shares one difftest AXIS packager input among
// NUM_SRC packet producers. A grant is held for up to BURST_LEN packets, so
// each packager buffer fill comes from a single source where possible. There
// is one IDLE cycle between consecutive grants.
//
// Ports:
//   m_axis_c2h_aclk     clock for all logic
//   m_axis_c2h_aresetn  synchronous active-low reset
//   src_valid/src_next  per-source valid / ready
//   src_data            packed per-source payloads, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_next  to/from packager data_valid / data_next
//   out_data            granted source payload, no added latency
//   out_src             index of the granted source
//   grant_active        high while a grant is held
//   stat_xfer_cnt       accepted packets, wrapping
//   stat_burst_cnt      grants issued, wrapping
module difftest_pkt_arbiter #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned SRC_W      = 2,
   parameter int unsigned DATA_WIDTH = 16000,
   parameter int unsigned BURST_LEN  = 8
) (
   input  logic                          m_axis_c2h_aclk,
   input  logic                          m_axis_c2h_aresetn,
   input  logic [NUM_SRC-1:0]            src_valid,
   output logic [NUM_SRC-1:0]            src_next,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic                          out_valid,
   input  logic                          out_next,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [SRC_W-1:0]              out_src,
   output logic                          grant_active,
   output logic [31:0]                   stat_xfer_cnt,
   output logic [31:0]                   stat_burst_cnt
);

   localparam int unsigned BCNT_W = 8;
   localparam int unsigned STAT_W = 32;

   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_e;

   state_e              state_q;
   logic [SRC_W-1:0]    gnt_q;
   logic [SRC_W-1:0]    rr_ptr_q;
   logic [BCNT_W-1:0]   burst_cnt_q;
   logic [STAT_W-1:0]   stat_xfer_q;
   logic [STAT_W-1:0]   stat_burst_q;

   logic [SRC_W-1:0]    gnt_d;
   logic [BCNT_W-1:0]   burst_cnt_d;
   logic                gnt_src_valid;
   logic                xfer;
   logic                last_xfer;
   logic                release_gnt;

   // Round-robin pick: first valid source scanning upward from rr_ptr+1.
   always_comb begin
      logic found;
      found = 1'b0;
      gnt_d = gnt_q;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         int unsigned idx;
         idx = (32'(rr_ptr_q) + k) % NUM_SRC;
         if (!found && src_valid[SRC_W'(idx)]) begin
            found = 1'b1;
            gnt_d = SRC_W'(idx);
         end
      end
   end

   assign grant_active  = (state_q == ST_GRANT);
   assign gnt_src_valid = src_valid[gnt_q];
   assign xfer          = grant_active & gnt_src_valid & out_next;
   assign burst_cnt_d   = burst_cnt_q + BCNT_W'(1);
   assign last_xfer     = xfer & (burst_cnt_q == BCNT_W'(BURST_LEN - 1));
   // A dry source releases the same way as a completed burst.
   assign release_gnt   = last_xfer | ~gnt_src_valid;

   // Output mux driven straight from the registered grant.
   always_comb begin
      src_next = '0;
      if (grant_active && out_next) begin
         src_next[gnt_q] = 1'b1;
      end
   end

   assign out_valid      = grant_active & gnt_src_valid;
   assign out_data       = src_data[32'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
   assign out_src        = gnt_q;
   assign stat_xfer_cnt  = stat_xfer_q;
   assign stat_burst_cnt = stat_burst_q;

   // Grant FSM, burst counter and statistics.
   always_ff @(posedge m_axis_c2h_aclk) begin
      if (!m_axis_c2h_aresetn) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         rr_ptr_q     <= SRC_W'(NUM_SRC - 1);
         burst_cnt_q  <= '0;
         stat_xfer_q  <= '0;
         stat_burst_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|src_valid) begin
                  gnt_q        <= gnt_d;
                  burst_cnt_q  <= '0;
                  stat_burst_q <= stat_burst_q + STAT_W'(1);
                  state_q      <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (xfer) begin
                  burst_cnt_q <= burst_cnt_d;
                  stat_xfer_q <= stat_xfer_q + STAT_W'(1);
               end
               if (release_gnt) begin
                  rr_ptr_q <= gnt_q;
                  state_q  <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/difftest_pkt_arbiter.md
Name: difftest_pkt_arbiter

Overview:
- Round-robin scheduler that shares the single FPGA-difftest AXIS packager input (data_valid/data_next/data) among NUM_SRC difftest packet producers, e.g. one per core.
- Grants one source at a time and holds the grant for a burst of up to BURST_LEN packets, so each ping-pong buffer fill comes from a single source where possible.
- Exports the granted source index and transfer statistics for the host-side unpacker and debug.
- Sits between the per-core difftest batch logic and the packager, in the packager's clock domain.

Parameters:
- NUM_SRC, 4, number of requesting producers (2..16).
- SRC_W, 2, width of source index; must equal clog2(NUM_SRC).
- DATA_WIDTH, 16000, packet width; identical to the packager's DATA_WIDTH.
- BURST_LEN, 8, max packets transferred per grant (1..255); default equals the packager's packets-per-buffer.

Ports:
- m_axis_c2h_aclk  in  1  single clock for all logic.
- m_axis_c2h_aresetn  in  1  synchronous, active-low reset.
- src_valid  in  NUM_SRC  per-source packet valid.
- src_next  out  NUM_SRC  per-source ready; transfer when src_valid[i] & src_next[i].
- src_data  in  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  to packager data_valid.
- out_next  in  1  from packager data_next (registered ready, may drop any cycle).
- out_data  out  DATA_WIDTH  to packager data.
- out_src  out  SRC_W  index of currently granted source.
- grant_active  out  1  high while in GRANT state.
- stat_xfer_cnt  out  32  total accepted packets, wraps at 2^32.
- stat_burst_cnt  out  32  number of grants issued, wraps at 2^32.

Behaviour:
- Reset (aresetn low at a clock edge, checked every cycle, including mid-burst):
  - state=IDLE, gnt=0, rr_ptr=NUM_SRC-1 (so source 0 wins first), burst_cnt=0, both stats=0.
  - Outputs: out_valid=0, src_next=0, out_src=0, grant_active=0.
  - A packet in flight is abandoned; no partial state survives.
- Transfer: xfer = grant_active & src_valid[gnt] & out_next.
- Output mux, combinational from registered gnt:
  - out_valid = grant_active & src_valid[gnt].
  - out_data = src_data slice gnt.
  - src_next[i] = grant_active & (gnt==i) & out_next.
  - All non-granted src_next are 0. No data is registered in this block, so there is no added data latency.
- IDLE state:
  - If any src_valid, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC.
  - Register the pick into gnt, set burst_cnt=0, increment stat_burst_cnt, go to GRANT.
  - If no src_valid, stay in IDLE.
  - Arbitration latency: src_valid rising in IDLE at cycle t gives out_valid=1 at t+1.
- GRANT state:
  - Each xfer increments burst_cnt and stat_xfer_cnt.
  - Release to IDLE, with rr_ptr<=gnt, when either:
    - (a) xfer occurs with burst_cnt==BURST_LEN-1, or
    - (b) src_valid[gnt]==0 in a cycle (the source ran dry).
  - Condition (a) has priority; both conditions release identically.
  - Back-pressure (out_next=0) with src_valid[gnt]=1 holds the grant indefinitely; there is no timeout.
  - Exactly one IDLE bubble cycle separates consecutive grants, even when other sources are waiting.
- Fairness: with all sources continuously valid, the grant order is 0,1,...,NUM_SRC-1,0,..., with BURST_LEN packets each.
- Sources must hold src_valid and src_data stable until accepted. The arbiter never drops or duplicates a packet.
- A source lowering src_valid without a transfer is a protocol violation. The arbiter still releases cleanly via (b).
- BURST_LEN=1 gives a per-packet round-robin.
- Stats counters wrap silently from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then src_valid=4'b0001 continuous, out_next=1 → grant at cycle 1, 8 transfers in cycles 1..8, IDLE at 9, re-grant source 0 at 10; stat_burst_cnt=2 after cycle 10.
- src_valid=4'b1111 continuous, out_next=1, BURST_LEN=8 → out_src sequence 0×8, idle, 1×8, idle, 2×8, idle, 3×8, idle, 0...; stat_xfer_cnt=32 after 4 bursts.
- Source 2 alone asserts valid for 3 packets, then drops → 3 transfers, release on the drop cycle, rr_ptr=2; then sources 1 and 3 valid → source 3 granted next.
- out_next low for 5 cycles mid-burst (packager both buffers full) → out_valid stays 1, no src_next pulses, burst_cnt frozen at its value, out_data unchanged; resumes with no loss.
- aresetn low for 1 cycle during burst_cnt=4 on source 1 → next cycle all outputs 0, state IDLE, stats 0; after reset source 0 wins first if valid.
- BURST_LEN=1, src_valid=4'b0110 → alternating grants 1,2,1,2 with one idle cycle between each; each src_next pulses exactly once per grant.
